madd_pipe_acc: RTL and testbench
================================

Name: madd_pipe_acc

Overview:
Parametrised successor to the fixed-width pipelined multiply-add. It computes a*b + c, or accumulates a*b into an internal accumulator, selected per beat. A valid bit travels with each beat through a configurable-depth multiplier pipeline. Sits in the sequential benchmark set as a streaming MAC datapath, free-running with no backpressure.

Parameters:
WIDTH, 8, bit width of unsigned operands a, b, c
MULT_STAGES, 2, register stages in the multiplier path (minimum 1)
ACC_WIDTH, 2*WIDTH+4, result/accumulator width (minimum 2*WIDTH+1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  beat present on a/b/c/mode/acc_clr this cycle
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
c  input  WIDTH  addend (mode 0) or accumulator seed (mode 1 with acc_clr)
mode  input  1  0 = multiply-add, 1 = accumulate
acc_clr  input  1  mode 1 only: reseed accumulator with c before adding
out_valid  output  1  s/overflow hold a new result this cycle
s  output  ACC_WIDTH  result
overflow  output  1  this result wrapped modulo 2^ACC_WIDTH

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: out_valid=0, s=0, overflow=0, accumulator=0, all pipeline valid bits cleared. rst dominates in_valid in the same cycle.
- Reset mid-operation: in-flight beats are discarded and never produce out_valid. Inputs are sampled normally from the first edge after rst deasserts.
- Latency L = MULT_STAGES + 1.
  - A beat sampled at edge t with in_valid=1 gives out_valid=1 for exactly one cycle after edge t+L.
  - Throughput is one beat per cycle.
- Sideband (c, mode, acc_clr, valid) is delayed alongside the product so every field stays aligned in the final stage.
- Arithmetic:
  - Product = a*b, full 2*WIDTH bits, unsigned.
  - All operands are zero-extended to ACC_WIDTH+1 before the add.
- Mode 0: s = product + c. overflow=0; it cannot occur given the ACC_WIDTH minimum. The accumulator is unchanged.
- Mode 1: acc_next = (acc_clr ? c : acc) + product.
  - Bit ACC_WIDTH of the sum drives overflow for that beat.
  - The accumulator and s take the sum modulo 2^ACC_WIDTH.
- acc_clr is ignored in mode 0.
- Accumulator update order follows beat order. Back-to-back mode-1 beats each see the previous beat's result, with no hazard, because the accumulator lives only in the final stage.
- Bubbles (in_valid=0) propagate as out_valid=0. s, overflow and the accumulator hold their last values.
- overflow is per-beat, not sticky. It updates only on valid beats.

Decomposition:
- Package madd_pkg:
  - MODE_MADD=1'b0, MODE_ACC=1'b1
  - function madd_latency(MULT_STAGES) returning MULT_STAGES+1
  - packed struct for the sideband (c, mode, acc_clr, valid), parametrised through a WIDTH localparam
- Sub-module madd_mult_pipe: MULT_STAGES-deep registered multiplier carrying the sideband, with rst clearing the valid bits only.
- Top level holds the final add/accumulate stage and the output registers.

Test Plan:
- Defaults (WIDTH=8, MULT_STAGES=2, ACC_WIDTH=20).
- Reset: hold rst 2 cycles with random inputs and in_valid=1 -> out_valid=0, s=0, overflow=0 through 5 cycles after release with in_valid=0.
- Mode 0: a=3, b=5, c=7, in_valid one cycle at edge t -> out_valid=1 only after edge t+3, s=22, overflow=0.
- Accumulate chain, back-to-back:
  - (clr, c=10, a=2, b=3) -> 16
  - (a=4, b=4) -> 32
  - (a=1, b=1) -> 33
  - Results on 3 consecutive cycles.
- Interleave: after acc=33, mode-0 beat a=2, b=2, c=1 -> s=5; next mode-1 beat a=1, b=0 -> s=33. Proves the accumulator is untouched by mode 0. Insert 2 bubbles between beats and check that s holds while out_valid=0.
- Overflow:
  - Beat 1: clr, c=255, a=b=255 -> 65280.
  - Beats 2-16: 15 mode-1 beats a=b=255 -> 1040655, overflow=0.
  - Beat 17: next such beat -> s=57104, overflow=1.
  - Following beat a=0, b=0 -> s=57104, overflow=0.
- Reset mid-flight: issue 3 valid beats, assert rst on the cycle after the third for 1 cycle -> no out_valid ever, accumulator reads 0 on the next mode-1 beat a=1, b=1 (s=1).

Source files
------------

// File: rtl/madd_pkg.sv
// Shared types and constants for the pipelined multiply-add / accumulate datapath.
// The sideband c field is sized for the widest supported operand (WIDTH <= SB_WIDTH).
package madd_pkg;

  localparam logic MODE_MADD = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int SB_WIDTH = 32;

  typedef struct packed {
    logic [SB_WIDTH-1:0] c;
    logic                mode;
    logic                acc_clr;
    logic                valid;
  } madd_sb_t;

  function automatic int madd_latency(input int mult_stages);
    return mult_stages + 32'sd1;
  endfunction

endpackage

// File: rtl/madd_mult_pipe.sv
// MULT_STAGES-deep registered unsigned multiplier; the beat sideband rides alongside
// the product so every field reaches the last stage together.
module madd_mult_pipe
  import madd_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  madd_sb_t           sb_in,
  output logic [2*WIDTH-1:0] prod,
  output madd_sb_t           sb_out
);

  logic [2*WIDTH-1:0] prod_d [MULT_STAGES];
  logic [2*WIDTH-1:0] prod_q [MULT_STAGES];
  madd_sb_t           sb_d   [MULT_STAGES];
  madd_sb_t           sb_q   [MULT_STAGES];

  // Reset only kills the valid bits; data lanes are don't-care without them.
  always_comb begin
    prod_d[0]       = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    sb_d[0]         = sb_in;
    sb_d[0].valid   = sb_in.valid & ~rst;
    for (int i = 1; i < MULT_STAGES; i++) begin
      prod_d[i]       = prod_q[i-1];
      sb_d[i]         = sb_q[i-1];
      sb_d[i].valid   = sb_q[i-1].valid & ~rst;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MULT_STAGES; i++) begin
      prod_q[i] <= prod_d[i];
      sb_q[i]   <= sb_d[i];
    end
  end

  assign prod   = prod_q[MULT_STAGES-1];
  assign sb_out = sb_q[MULT_STAGES-1];

endmodule

// File: rtl/madd_pipe_acc.sv
// Streaming MAC: s = a*b + c (mode 0) or acc = (acc_clr ? c : acc) + a*b (mode 1).
// Multiplier pipeline, then a final add/accumulate stage, then registered outputs.
module madd_pipe_acc
  import madd_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 2,
  parameter int ACC_WIDTH   = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] s,
  output logic                 overflow
);

  localparam int SUM_W = ACC_WIDTH + 1;

  madd_sb_t           sb_in_s;
  madd_sb_t           sb_m_s;
  logic [2*WIDTH-1:0] prod_m_s;

  logic [SUM_W-1:0]     c_ext_s;
  logic [SUM_W-1:0]     p_ext_s;
  logic [SUM_W-1:0]     base_s;
  logic [SUM_W-1:0]     sum_s;
  logic                 unused_c_hi_s;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [ACC_WIDTH-1:0] res_d, res_q;
  logic                 res_ovf_d, res_ovf_q;
  logic                 res_valid_d, res_valid_q;
  logic [ACC_WIDTH-1:0] s_d, s_q;
  logic                 overflow_d, overflow_q;
  logic                 out_valid_d, out_valid_q;

  always_comb begin
    sb_in_s         = '0;
    sb_in_s.c       = SB_WIDTH'(c);
    sb_in_s.mode    = mode;
    sb_in_s.acc_clr = acc_clr;
    sb_in_s.valid   = in_valid;
  end

  madd_mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .sb_in  (sb_in_s),
    .prod   (prod_m_s),
    .sb_out (sb_m_s)
  );

  assign unused_c_hi_s = ^(sb_m_s.c >> WIDTH);

  // Final stage: the accumulator only lives here, so back-to-back mode-1 beats chain cleanly.
  always_comb begin
    c_ext_s     = SUM_W'(WIDTH'(sb_m_s.c));
    p_ext_s     = SUM_W'(prod_m_s);
    base_s      = sb_m_s.acc_clr ? c_ext_s : SUM_W'(acc_q);
    sum_s       = '0;
    acc_d       = acc_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = sb_m_s.valid;
    if (sb_m_s.valid) begin
      case (sb_m_s.mode)
        MODE_MADD: begin
          sum_s     = c_ext_s + p_ext_s;
          res_d     = sum_s[ACC_WIDTH-1:0];
          res_ovf_d = 1'b0;
        end
        MODE_ACC: begin
          sum_s     = base_s + p_ext_s;
          res_d     = sum_s[ACC_WIDTH-1:0];
          acc_d     = sum_s[ACC_WIDTH-1:0];
          res_ovf_d = sum_s[ACC_WIDTH];
        end
        default: begin
          sum_s = '0;
        end
      endcase
    end else begin
      sum_s = '0;
    end
  end

  always_comb begin
    out_valid_d = res_valid_q;
    if (res_valid_q) begin
      s_d        = res_q;
      overflow_d = res_ovf_q;
    end else begin
      s_d        = s_q;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      s_q         <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      s_q         <= s_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_madd_pipe_acc.sv
// Scoreboard bench for madd_pipe_acc: driver pushes expected results from a plain
// arithmetic model; an independent monitor pops and compares on every out_valid.
module tb_madd_pipe_acc;
  import madd_pkg::*;

  localparam int WIDTH = 8;
  localparam int MS    = 2;
  localparam int AW    = 2*WIDTH+4;
  localparam int L     = madd_latency(MS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    a = 8'd0, b = 8'd0, c = 8'd0;
  logic          mode = 1'b0, acc_clr = 1'b0;
  logic          out_valid;
  logic [AW-1:0] s;
  logic          overflow;

  madd_pipe_acc #(.WIDTH(WIDTH), .MULT_STAGES(MS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid), .s(s), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint s;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  longint model_acc = 0;
  int     checks = 0;
  int     passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // One driven cycle; a valid beat gets its expected result computed from the arithmetic rules.
  task automatic beat(input bit v, input bit m, input bit clr,
                      input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] cc);
    exp_t   e;
    longint p;
    longint sum;
    @(negedge clk);
    rst = 1'b0; in_valid = v; mode = m; acc_clr = clr; a = aa; b = bb; c = cc;
    if (v) begin
      p = longint'(aa) * longint'(bb);
      if (m == MODE_MADD) begin
        e.s   = p + longint'(cc);
        e.ovf = 1'b0;
      end else begin
        sum       = (clr ? longint'(cc) : model_acc) + p;
        e.ovf     = (sum >= (64'sd1 <<< AW));
        e.s       = sum % (64'sd1 <<< AW);
        model_acc = e.s;
      end
      e.cyc = cyc + 1 + L;
      q.push_back(e);
    end
  endtask

  task automatic bubbles(input int n);
    repeat (n) beat(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; mode = 1'($urandom); acc_clr = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      model_acc = 0;
      while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
    end
  endtask

  // Monitor: decoupled from the driver, samples just after each rising edge.
  longint hold_s = 0;
  bit     hold_ovf = 1'b0;
  bit     started = 1'b0;
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        started = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        hold_s = 0; hold_ovf = 1'b0;
      end else if (started) begin
        exp_v = (q.size() > 0) && (q[0].cyc == cyc);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
          e = q.pop_front();
          if (out_valid) begin
            chk("s", 64'(s), 64'(e.s));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            hold_s = e.s; hold_ovf = e.ovf;
          end
        end else if (!out_valid) begin
          chk("hold_s", 64'(s), 64'(hold_s));
          chk("hold_overflow", 64'(overflow), 64'(hold_ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    // Reset with live inputs, then idle with in_valid low.
    do_reset(2);
    bubbles(5);
    // Multiply-add: 3*5+7.
    beat(1'b1, MODE_MADD, 1'b0, 8'd3, 8'd5, 8'd7);
    bubbles(4);
    // Back-to-back accumulate chain: 16, 32, 33.
    beat(1'b1, MODE_ACC, 1'b1, 8'd2, 8'd3, 8'd10);
    beat(1'b1, MODE_ACC, 1'b0, 8'd4, 8'd4, 8'd99);
    beat(1'b1, MODE_ACC, 1'b0, 8'd1, 8'd1, 8'd77);
    bubbles(4);
    // Mode 0 leaves the accumulator alone.
    beat(1'b1, MODE_MADD, 1'b1, 8'd2, 8'd2, 8'd1);
    bubbles(2);
    beat(1'b1, MODE_ACC, 1'b0, 8'd1, 8'd0, 8'd55);
    bubbles(4);
    // Overflow: seed, 15 more without wrap, 17th wraps, then a zero product.
    beat(1'b1, MODE_ACC, 1'b1, 8'd255, 8'd255, 8'd255);
    repeat (15) beat(1'b1, MODE_ACC, 1'b0, 8'd255, 8'd255, 8'd0);
    beat(1'b1, MODE_ACC, 1'b0, 8'd255, 8'd255, 8'd0);
    beat(1'b1, MODE_ACC, 1'b0, 8'd0, 8'd0, 8'd0);
    bubbles(5);
    // Reset with three beats in flight; accumulator must restart from zero.
    beat(1'b1, MODE_ACC, 1'b0, 8'd9, 8'd9, 8'd0);
    beat(1'b1, MODE_MADD, 1'b0, 8'd7, 8'd7, 8'd7);
    beat(1'b1, MODE_ACC, 1'b0, 8'd5, 8'd5, 8'd0);
    do_reset(1);
    bubbles(5);
    beat(1'b1, MODE_ACC, 1'b0, 8'd1, 8'd1, 8'd0);
    bubbles(5);
    // Randomized traffic with occasional resets; operands biased towards the top value.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset(1 + $urandom_range(0, 1));
      end else begin
        beat($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
             ($urandom_range(0, 1) != 0) ? 8'd255 : 8'($urandom),
             ($urandom_range(0, 1) != 0) ? 8'd255 : 8'($urandom),
             8'($urandom));
      end
    end
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      bubbles(1);
      guard++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    bubbles(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
